// File: rtl/global_sum_layer.sv
// Per-channel global sum pooling: accumulates every pixel of a frame per channel
// and emits one summed vector per frame over an elastic valid/ready stream.
module global_sum_layer #(
   parameter int LineWidthPx = 4,
   parameter int LineCountPx = 3,
   parameter int WidthIn     = 1,
   parameter int InChannels  = 1,
   localparam int PixelCount = LineWidthPx * LineCountPx,
   localparam int SumGrowth  = ($clog2(PixelCount) > 1) ? $clog2(PixelCount) : 1,
   localparam int WidthOut   = WidthIn + SumGrowth
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 valid_i,
   output logic                                 ready_o,
   input  logic [InChannels-1:0][WidthIn-1:0]   data_i,
   output logic                                 valid_o,
   input  logic                                 ready_i,
   output logic [InChannels-1:0][WidthOut-1:0]  data_o
);

   localparam int XW = (LineWidthPx > 1) ? $clog2(LineWidthPx) : 1;
   localparam int YW = (LineCountPx > 1) ? $clog2(LineCountPx) : 1;
   localparam logic [XW-1:0] XLast = XW'(LineWidthPx - 1);
   localparam logic [YW-1:0] YLast = YW'(LineCountPx - 1);

   logic [XW-1:0]                        x_pos;
   logic [YW-1:0]                        y_pos;
   logic [InChannels-1:0][WidthOut-1:0]  acc;
   logic [InChannels-1:0][WidthOut-1:0]  acc_sum;
   logic [InChannels-1:0][WidthOut-1:0]  sum_r;
   logic                                 valid_r;
   logic                                 last_col;
   logic                                 last_row;
   logic                                 last_px;
   logic                                 in_fire;
   logic                                 out_fire;

   assign last_col = (x_pos == XLast);
   assign last_row = (y_pos == YLast);
   assign last_px  = last_col & last_row;

   // NOTE: ready_o depends combinationally on ready_i so the frame-closing pixel
   // can fire in the same cycle the previous sum drains, giving no gap between frames.
   assign ready_o  = !(last_px && valid_r && !ready_i);
   assign in_fire  = valid_i & ready_o;
   assign out_fire = valid_r & ready_i;

   assign valid_o  = valid_r;
   assign data_o   = sum_r;

   always_comb begin
      acc_sum = '0;
      for (int ch = 0; ch < InChannels; ch++) begin
         acc_sum[ch] = acc[ch] + WidthOut'(data_i[ch]);
      end
   end

   always_ff @(posedge clk_i) begin
      // NOTE: the accumulators are a handful of flops, not a RAM, so they are
      // reset with everything else; an aborted frame must leave no residue.
      if (!rst_ni) begin
         x_pos   <= '0;
         y_pos   <= '0;
         acc     <= '0;
         sum_r   <= '0;
         valid_r <= 1'b0;
      end else begin
         if (out_fire) begin
            valid_r <= 1'b0;
         end
         if (in_fire) begin
            if (last_px) begin
               valid_r <= 1'b1;
               sum_r   <= acc_sum;
               acc     <= '0;
               x_pos   <= '0;
               y_pos   <= '0;
            end else begin
               acc <= acc_sum;
               if (last_col) begin
                  x_pos <= '0;
                  y_pos <= y_pos + 1'b1;
               end else begin
                  x_pos <= x_pos + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_global_sum_layer.sv
// Bench for global_sum_layer: three configurations driven cycle by cycle and
// compared against a pixel-count / running-sum model of the pooling stage.
module tb_global_sum_layer;

   localparam int A_PC = 12;  // 4x3, WidthIn=1, 2 channels -> WidthOut=5
   localparam int B_PC = 12;  // 4x3, WidthIn=4, 1 channel  -> WidthOut=8
   localparam int C_PC = 1;   // 1x1, WidthIn=3, 1 channel  -> WidthOut=4

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic             va, ra_o, rdy_a, vo_a;
   logic [1:0][0:0]  da;
   logic [1:0][4:0]  qa;

   logic             vb, rb_o, rdy_b, vo_b;
   logic [0:0][3:0]  db;
   logic [0:0][7:0]  qb;

   logic             vc, rc_o, rdy_c, vo_c;
   logic [0:0][2:0]  dc;
   logic [0:0][3:0]  qc;

   global_sum_layer #(.LineWidthPx(4), .LineCountPx(3), .WidthIn(1), .InChannels(2)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(va), .ready_o(ra_o), .data_i(da),
      .valid_o(vo_a), .ready_i(rdy_a), .data_o(qa));

   global_sum_layer #(.LineWidthPx(4), .LineCountPx(3), .WidthIn(4), .InChannels(1)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(vb), .ready_o(rb_o), .data_i(db),
      .valid_o(vo_b), .ready_i(rdy_b), .data_o(qb));

   global_sum_layer #(.LineWidthPx(1), .LineCountPx(1), .WidthIn(3), .InChannels(1)) dut_c (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(vc), .ready_o(rc_o), .data_i(dc),
      .valid_o(vo_c), .ready_i(rdy_c), .data_o(qc));

   int checks = 0;
   int errors = 0;

   // Reference model: pixels accepted so far in the frame, running sums, one output slot.
   int a_cnt, a_acc[2], a_exp[2];
   bit a_pend;
   int b_cnt, b_acc, b_exp;
   bit b_pend;
   int c_cnt, c_acc, c_exp;
   bit c_pend;

   logic [9:0] got_a[$];
   logic [7:0] got_b[$];
   logic [3:0] got_c[$];

   function automatic void reset_models();
      a_cnt = 0; a_acc = '{0, 0}; a_exp = '{0, 0}; a_pend = 0;
      b_cnt = 0; b_acc = 0; b_exp = 0; b_pend = 0;
      c_cnt = 0; c_acc = 0; c_exp = 0; c_pend = 0;
   endfunction

   task automatic step_a(input logic v, input logic [1:0] d, input logic r);
      logic exp_rdy;
      bit in_f, out_f;
      @(negedge clk);
      va = v; da[0] = d[0]; da[1] = d[1]; rdy_a = r;
      #1;
      exp_rdy = !((a_cnt == A_PC - 1) && a_pend && !r);
      checks++;
      if (ra_o !== exp_rdy) begin
         errors++; $display("FAIL a_ready_o got %b exp %b", ra_o, exp_rdy);
      end
      checks++;
      if (vo_a !== a_pend) begin
         errors++; $display("FAIL a_valid_o got %b exp %b", vo_a, a_pend);
      end
      if (a_pend) begin
         checks++;
         if (qa[0] !== 5'(a_exp[0]) || qa[1] !== 5'(a_exp[1])) begin
            errors++; $display("FAIL a_data_o got %0d,%0d exp %0d,%0d", qa[1], qa[0], a_exp[1], a_exp[0]);
         end
      end
      in_f  = v && exp_rdy;
      out_f = a_pend && r;
      if (out_f) got_a.push_back(qa);
      @(posedge clk);
      if (out_f) a_pend = 0;
      if (in_f) begin
         a_acc[0] += int'(d[0]);
         a_acc[1] += int'(d[1]);
         if (a_cnt == A_PC - 1) begin
            a_pend = 1; a_exp = a_acc; a_acc = '{0, 0}; a_cnt = 0;
         end else a_cnt++;
      end
   endtask

   task automatic step_b(input logic v, input logic [3:0] d, input logic r);
      logic exp_rdy;
      bit in_f, out_f;
      @(negedge clk);
      vb = v; db[0] = d; rdy_b = r;
      #1;
      exp_rdy = !((b_cnt == B_PC - 1) && b_pend && !r);
      checks++;
      if (rb_o !== exp_rdy) begin
         errors++; $display("FAIL b_ready_o got %b exp %b", rb_o, exp_rdy);
      end
      checks++;
      if (vo_b !== b_pend) begin
         errors++; $display("FAIL b_valid_o got %b exp %b", vo_b, b_pend);
      end
      if (b_pend) begin
         checks++;
         if (qb[0] !== 8'(b_exp)) begin
            errors++; $display("FAIL b_data_o got %0d exp %0d", qb[0], b_exp);
         end
      end
      in_f  = v && exp_rdy;
      out_f = b_pend && r;
      if (out_f) got_b.push_back(qb[0]);
      @(posedge clk);
      if (out_f) b_pend = 0;
      if (in_f) begin
         b_acc += int'(d);
         if (b_cnt == B_PC - 1) begin
            b_pend = 1; b_exp = b_acc; b_acc = 0; b_cnt = 0;
         end else b_cnt++;
      end
   endtask

   task automatic step_c(input logic v, input logic [2:0] d, input logic r);
      logic exp_rdy;
      bit in_f, out_f;
      @(negedge clk);
      vc = v; dc[0] = d; rdy_c = r;
      #1;
      exp_rdy = !((c_cnt == C_PC - 1) && c_pend && !r);
      checks++;
      if (rc_o !== exp_rdy) begin
         errors++; $display("FAIL c_ready_o got %b exp %b", rc_o, exp_rdy);
      end
      checks++;
      if (vo_c !== c_pend) begin
         errors++; $display("FAIL c_valid_o got %b exp %b", vo_c, c_pend);
      end
      if (c_pend) begin
         checks++;
         if (qc[0] !== 4'(c_exp)) begin
            errors++; $display("FAIL c_data_o got %0d exp %0d", qc[0], c_exp);
         end
      end
      in_f  = v && exp_rdy;
      out_f = c_pend && r;
      if (out_f) got_c.push_back(qc[0]);
      @(posedge clk);
      if (out_f) c_pend = 0;
      if (in_f) begin
         c_acc += int'(d);
         if (c_cnt == C_PC - 1) begin
            c_pend = 1; c_exp = c_acc; c_acc = 0; c_cnt = 0;
         end else c_cnt++;
      end
   endtask

   task automatic test_reset();
      int s;
      logic [3:0] d;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      reset_models();
      checks++;
      if (vo_a !== 1'b0 || vo_b !== 1'b0 || vo_c !== 1'b0) begin
         errors++; $display("FAIL reset_valid_o got %b%b%b exp 000", vo_a, vo_b, vo_c);
      end
      checks++;
      if (qa !== '0 || qb !== '0 || qc !== '0) begin
         errors++; $display("FAIL reset_data_o got %h %h %h exp 0", qa, qb, qc);
      end
      checks++;
      if (ra_o !== 1'b1 || rb_o !== 1'b1 || rc_o !== 1'b1) begin
         errors++; $display("FAIL reset_ready_o got %b%b%b exp 111", ra_o, rb_o, rc_o);
      end
      rst_n = 1'b1;
      got_b.delete();
      s = 0;
      for (int i = 0; i < B_PC; i++) begin
         d = 4'($urandom_range(0, 15));
         s += int'(d);
         step_b(1'b1, d, 1'b1);
      end
      repeat (3) step_b(1'b0, 4'd0, 1'b1);
      checks++;
      if (got_b.size() != 1 || got_b[0] !== 8'(s)) begin
         errors++; $display("FAIL reset_first_frame got %0d outputs exp 1 output of %0d", got_b.size(), s);
      end
   endtask

   task automatic test_all_ones();
      got_a.delete();
      for (int i = 0; i < A_PC; i++) step_a(1'b1, 2'b11, 1'b1);
      repeat (2) step_a(1'b0, 2'b00, 1'b1);
      checks++;
      if (got_a.size() != 1 || got_a[0] !== {5'd12, 5'd12}) begin
         errors++; $display("FAIL all_ones got %0d outputs first %h exp 1 output of {12,12}",
                            got_a.size(), (got_a.size() > 0) ? got_a[0] : 10'h0);
      end
   endtask

   task automatic test_max_back_to_back();
      got_b.delete();
      for (int i = 0; i < B_PC; i++) step_b(1'b1, 4'd15, 1'b1);
      for (int k = 0; k < B_PC; k++) step_b(1'b1, 4'(k), 1'b1);
      repeat (2) step_b(1'b0, 4'd0, 1'b1);
      checks++;
      if (got_b.size() != 2 || got_b[0] !== 8'd180 || got_b[1] !== 8'd66) begin
         errors++; $display("FAIL max_back_to_back got %0d outputs exp 180 then 66", got_b.size());
      end
   endtask

   task automatic test_backpressure();
      int s1, s2;
      logic [3:0] d, last;
      got_b.delete();
      s1 = 0; s2 = 0;
      for (int i = 0; i < B_PC; i++) begin
         d = 4'($urandom_range(0, 15));
         s1 += int'(d);
         step_b(1'b1, d, (i < B_PC - 1));
      end
      for (int i = 0; i < B_PC - 1; i++) begin
         d = 4'($urandom_range(0, 15));
         s2 += int'(d);
         step_b(1'b1, d, 1'b0);
      end
      last = 4'($urandom_range(0, 15));
      s2 += int'(last);
      repeat (3) step_b(1'b1, last, 1'b0);
      @(negedge clk);
      #1;
      checks++;
      if (rb_o !== 1'b0 || vo_b !== 1'b1 || qb[0] !== 8'(s1)) begin
         errors++; $display("FAIL backpressure_hold got ready %b valid %b data %0d exp 0 1 %0d",
                            rb_o, vo_b, qb[0], s1);
      end
      step_b(1'b1, last, 1'b1);
      repeat (2) step_b(1'b0, 4'd0, 1'b1);
      checks++;
      if (got_b.size() != 2 || got_b[0] !== 8'(s1) || got_b[1] !== 8'(s2)) begin
         errors++; $display("FAIL backpressure_sums got %0d outputs exp %0d then %0d", got_b.size(), s1, s2);
      end
   endtask

   task automatic test_reset_mid_frame();
      for (int i = 0; i < 7; i++) step_a(1'b1, 2'b11, 1'b1);
      @(negedge clk);
      va = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      reset_models();
      got_a.delete();
      for (int i = 0; i < A_PC; i++) step_a(1'b1, 2'b01, 1'b1);
      repeat (2) step_a(1'b0, 2'b00, 1'b1);
      checks++;
      if (got_a.size() != 1 || got_a[0] !== {5'd0, 5'd12}) begin
         errors++; $display("FAIL reset_mid_frame got %0d outputs first %h exp 1 output of {0,12}",
                            got_a.size(), (got_a.size() > 0) ? got_a[0] : 10'h0);
      end
   endtask

   task automatic test_one_by_one();
      got_c.delete();
      step_c(1'b1, 3'd5, 1'b1);
      step_c(1'b1, 3'd7, 1'b1);
      step_c(1'b1, 3'd2, 1'b1);
      repeat (2) step_c(1'b0, 3'd0, 1'b1);
      checks++;
      if (got_c.size() != 3 || got_c[0] !== 4'd5 || got_c[1] !== 4'd7 || got_c[2] !== 4'd2) begin
         errors++; $display("FAIL one_by_one got %0d outputs exp 5,7,2", got_c.size());
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         step_b($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0);
      end
      for (int i = 0; i < 300; i++) begin
         step_a($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0);
      end
      for (int i = 0; i < 60; i++) begin
         step_c($urandom_range(0, 1) != 0, 3'($urandom_range(0, 7)), $urandom_range(0, 1) != 0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      va = 1'b0; da = '0; rdy_a = 1'b1;
      vb = 1'b0; db = '0; rdy_b = 1'b1;
      vc = 1'b0; dc = '0; rdy_c = 1'b1;
      reset_models();
      test_reset();
      test_all_ones();
      test_max_back_to_back();
      test_backpressure();
      test_reset_mid_frame();
      test_one_by_one();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
